// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame path (transmitter and its demux
// consumer): field widths, line levels, FSM states and the header payload.
//   PORT_W / LEN_W   : widths of the port and length header fields
//   START_BIT        : level of the frame start bit
//   IDLE_LEVEL       : level of the line between frames
//   FRAME_HDR_BITS   : bit periods before the payload (start + port + len)
package serial_frame_pkg;

  localparam int unsigned PORT_W         = 2;
  localparam int unsigned LEN_W          = 5;
  localparam int unsigned FRAME_HDR_BITS = 1 + PORT_W + LEN_W;

  localparam logic START_BIT  = 1'b0;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PORT,
    LEN,
    DATA
  } state_t;

  // Header fields in transmit order, MSB-first.
  typedef struct packed {
    logic [PORT_W-1:0] port;
    logic [LEN_W-1:0]  len;
  } frame_hdr_t;

  // Total bit periods for a frame carrying len payload bits.
  function automatic int unsigned frame_bits(input int unsigned len);
    return FRAME_HDR_BITS + len;
  endfunction

endpackage

// File: rtl/frame_piso.sv
// Parallel-load, MSB-first shift-out register.
//   clk, rst : clock and synchronous active-high reset
//   clk_en   : step enable qualifying both load and shift
//   ld       : load din (has priority over sh)
//   sh       : shift left by one, zero fill
//   din      : parallel load value, MSB is emitted first
//   msb      : current most significant bit of the register
module frame_piso #(
  parameter int unsigned W = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         ld,
  input  logic         sh,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  // Shift register core.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (clk_en) begin
      if (ld) begin
        sr <= din;
      end else if (sh) begin
        sr <= {sr[W-2:0], 1'b0};
      end
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: turns a parallel request (port, length, payload)
// into the MSB-first bit stream start(0), port, len, payload[len-1:0].
// The line idles high and every step is qualified by clk_en.
//   clk, rst   : clock and synchronous active-high reset
//   clk_en     : one bit period per enabled cycle
//   in_valid   : frame request present
//   in_ready   : block is idle and can accept a request (from state)
//   in_port    : destination port
//   in_len     : payload bit count, 0..PAYLOAD_W
//   in_data    : payload, bits [len-1:0] are sent
//   ser_out    : registered serial line
//   busy       : registered, frame in progress
//   frame_done : one clk pulse after the last bit period ends
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PORT_W-1:0]    in_port,
  input  logic [LEN_W-1:0]     in_len,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 ser_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned CLOG_PW = $clog2(PAYLOAD_W);
  localparam int unsigned CNT_W   = (LEN_W > CLOG_PW) ? LEN_W : CLOG_PW;
  localparam int unsigned SR_W    = PORT_W + LEN_W + PAYLOAD_W;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [LEN_W-1:0]     len_r;
  logic [LEN_W-1:0]     len_c;
  logic [PAYLOAD_W-1:0] data_al;
  frame_hdr_t           hdr;
  logic                 piso_ld;
  logic                 piso_sh;
  logic                 piso_msb;

  assign in_ready = (state == IDLE);

  // Clamp is only meaningful when the length field can exceed the payload.
  if (PAYLOAD_W < (2 ** LEN_W) - 1) begin : g_clamp
    assign len_c = (in_len > LEN_W'(PAYLOAD_W)) ? LEN_W'(PAYLOAD_W) : in_len;
  end else begin : g_noclamp
    assign len_c = in_len;
  end

  // Left-align the payload so data[len-1] follows len[0] directly.
  assign data_al = in_data << (PAYLOAD_W - 32'(len_c));
  assign hdr     = '{port: in_port, len: len_c};

  // Load on acceptance; every bit period after the start bit shifts one out.
  assign piso_ld = in_valid & in_ready;
  assign piso_sh = (state != IDLE);

  frame_piso #(
    .W (SR_W)
  ) u_piso (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .ld     (piso_ld),
    .sh     (piso_sh),
    .din    ({hdr, data_al}),
    .msb    (piso_msb)
  );

  // Frame sequencer: walks the fields, counting bits with one down-counter.
  always_ff @(posedge clk) begin
    frame_done <= 1'b0;
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      len_r   <= '0;
      ser_out <= IDLE_LEVEL;
      busy    <= 1'b0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state   <= START;
            len_r   <= len_c;
            ser_out <= START_BIT;
            busy    <= 1'b1;
          end
        end

        START: begin
          state   <= PORT;
          cnt     <= CNT_W'(PORT_W - 1);
          ser_out <= piso_msb;
        end

        PORT: begin
          ser_out <= piso_msb;
          if (cnt == '0) begin
            state <= LEN;
            cnt   <= CNT_W'(LEN_W - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        LEN: begin
          if (cnt != '0) begin
            ser_out <= piso_msb;
            cnt     <= cnt - CNT_W'(1);
          end else if (len_r != '0) begin
            state   <= DATA;
            ser_out <= piso_msb;
            cnt     <= CNT_W'(len_r) - CNT_W'(1);
          end else begin
            // Zero-length frame ends after the header.
            state      <= IDLE;
            ser_out    <= IDLE_LEVEL;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end

        DATA: begin
          if (cnt != '0) begin
            ser_out <= piso_msb;
            cnt     <= cnt - CNT_W'(1);
          end else begin
            state      <= IDLE;
            ser_out    <= IDLE_LEVEL;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          ser_out <= IDLE_LEVEL;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: a queue-based frame model checked
// every cycle, plus directed frames compared against hand-written bit strings.
module tb_serial_frame_tx;
  import serial_frame_pkg::*;

  localparam int unsigned PAYLOAD_W = 31;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clk_en;
  logic                 in_valid;
  logic                 in_ready;
  logic [PORT_W-1:0]    in_port;
  logic [LEN_W-1:0]     in_len;
  logic [PAYLOAD_W-1:0] in_data;
  logic                 ser_out;
  logic                 busy;
  logic                 frame_done;

  int errors = 0;
  int checks = 0;

  serial_frame_tx #(
    .PAYLOAD_W (PAYLOAD_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_port    (in_port),
    .in_len     (in_len),
    .in_data    (in_data),
    .ser_out    (ser_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Enable pattern: high once every en_period clocks, changed away from edges.
  int en_period = 1;
  int en_cnt    = 0;
  always @(posedge clk) begin
    #2;
    en_cnt = (en_cnt + 1 >= en_period) ? 0 : en_cnt + 1;
    clk_en = (en_cnt == 0);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the frame is the list of line levels still to be sent.
  bit          q[$];
  bit          active   = 1'b0;
  bit          model_on = 1'b0;
  logic        exp_ser  = 1'b1;
  logic        exp_done = 1'b0;
  int unsigned mlen;

  always @(posedge clk) begin
    exp_done = 1'b0;
    if (rst) begin
      q.delete();
      active   = 1'b0;
      exp_ser  = 1'b1;
      model_on = 1'b1;
    end else if (model_on && clk_en) begin
      if (active) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          active   = 1'b0;
          exp_ser  = 1'b1;
          exp_done = 1'b1;
        end else begin
          exp_ser = q[0];
        end
      end else if (in_valid) begin
        mlen = (int'(in_len) > int'(PAYLOAD_W)) ? PAYLOAD_W : int'(in_len);
        q.push_back(1'b0);
        for (int i = PORT_W - 1; i >= 0; i--) q.push_back(in_port[i]);
        for (int i = LEN_W - 1; i >= 0; i--) q.push_back(mlen[i]);
        for (int i = int'(mlen) - 1; i >= 0; i--) q.push_back(in_data[i]);
        active  = 1'b1;
        exp_ser = q[0];
      end
    end
    #1;
    if (model_on) begin
      chk("model_ser_out", 64'(ser_out), 64'(exp_ser));
      chk("model_busy", 64'(busy), 64'(active));
      chk("model_frame_done", 64'(frame_done), 64'(exp_done));
      chk("model_in_ready", 64'(in_ready), 64'(!active));
    end
  end

  // Advance to just after the next enabled rising edge.
  task automatic wait_en_edge();
    int w;
    w = 0;
    @(negedge clk);
    while (!clk_en) begin
      @(negedge clk);
      w++;
      if (w > 50) begin
        chk("enable_timeout", 64'(w), 64'(0));
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Send one frame and compare the line against lit (n bits, first bit at lit[n-1]).
  task automatic send_frame(input string tag, input logic [1:0] p, input logic [4:0] l,
                            input logic [30:0] d, input logic [63:0] lit, input int n,
                            input bit keep_valid, input bit expect_now);
    int waits;
    @(negedge clk);
    in_port  = p;
    in_len   = l;
    in_data  = d;
    in_valid = 1'b1;
    waits    = 0;
    while (!(clk_en && in_ready)) begin
      @(negedge clk);
      waits++;
      if (waits > 200) begin
        chk({tag, "_accept_timeout"}, 64'(waits), 64'(0));
        in_valid = 1'b0;
        return;
      end
    end
    if (expect_now) chk({tag, "_gap"}, 64'(waits), 64'(0));
    @(posedge clk);
    #1;
    if (!keep_valid) in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) wait_en_edge();
      chk($sformatf("%s_bit%0d", tag, i), 64'(ser_out), 64'(lit[n-1-i]));
      chk($sformatf("%s_busy%0d", tag, i), 64'(busy), 64'(1));
    end
    wait_en_edge();
    chk({tag, "_done"}, 64'(frame_done), 64'(1));
    chk({tag, "_idle_after"}, 64'(ser_out), 64'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    clk_en   = 1'b1;
    in_valid = 1'b0;
    in_port  = '0;
    in_len   = '0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("idle_ser_out", 64'(ser_out), 64'(1));
      chk("idle_in_ready", 64'(in_ready), 64'(1));
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_frame_done", 64'(frame_done), 64'(0));
    end

    // Basic frame: 0 10 00011 101.
    send_frame("basic", 2'd2, 5'd3, 31'b101, 64'(11'b0_10_00011_101), 11, 1'b0, 1'b0);
    repeat (3) @(posedge clk);

    // Zero length: header only, payload bits must not appear.
    send_frame("zero", 2'd3, 5'd0, 31'h7FFF_FFFF, 64'(8'b0_11_00000), 8, 1'b0, 1'b0);
    repeat (3) @(posedge clk);

    // Slow enable: every third clock.
    en_period = 3;
    repeat (6) @(posedge clk);
    send_frame("slow", 2'd1, 5'd2, 31'b10, 64'(10'b0_01_00010_10), 10, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    en_period = 1;
    repeat (4) @(posedge clk);

    // Back-to-back with in_valid held high.
    send_frame("b2b1", 2'd1, 5'd1, 31'b1, 64'(9'b0_01_00001_1), 9, 1'b1, 1'b0);
    send_frame("b2b2", 2'd0, 5'd31, 31'h7FFF_FFFF,
               64'({1'b0, 2'b00, 5'b11111, 31'h7FFF_FFFF}), 39, 1'b0, 1'b1);
    repeat (3) @(posedge clk);

    // Reset in the middle of the LEN field.
    @(negedge clk);
    in_port  = 2'd2;
    in_len   = 5'd3;
    in_data  = 31'b101;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("rst_mid_started", 64'(busy), 64'(1));
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_in_len", 64'(ser_out), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_ser_out", 64'(ser_out), 64'(1));
    chk("rst_mid_in_ready", 64'(in_ready), 64'(1));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_done", 64'(frame_done), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("rst_mid_no_done", 64'(frame_done), 64'(0));
    end
    send_frame("after_rst", 2'd3, 5'd4, 31'b1001, 64'(12'b0_11_00100_1001), 12, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
